// File: rtl/start_sequencer_if.sv
// Control and status bundle between the StartSignal PIO side and start_sequencer.
// With START_SEQUENCER_STATUS_EN defined it also carries the Avalon-MM status read port.
interface start_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       ctrl_in;
  logic             run_out;
  logic             busy;
  logic             done_pulse;
  logic             aborted;
  logic [CNT_W-1:0] run_count;

`ifdef START_SEQUENCER_STATUS_EN
  logic             status_address;
  logic             status_chipselect;
  logic [31:0]      status_readdata;

  modport master (
    output ctrl_in,
    input  run_out, busy, done_pulse, aborted, run_count,
    output status_address, status_chipselect,
    input  status_readdata
  );

  modport slave (
    input  ctrl_in,
    output run_out, busy, done_pulse, aborted, run_count,
    input  status_address, status_chipselect,
    output status_readdata
  );
`else
  modport master (
    output ctrl_in,
    input  run_out, busy, done_pulse, aborted, run_count
  );

  modport slave (
    input  ctrl_in,
    output run_out, busy, done_pulse, aborted, run_count
  );
`endif
endinterface

// File: rtl/start_sequencer.sv
// Turns the synchronized PIO start level into an ARM -> RUN -> DONE sequence with abort;
// START_SEQUENCER_STATUS_EN adds a combinational Avalon-MM status read port.
module start_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 16,
  parameter int RUN_CYCLES   = 1000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  start_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LOAD = (SETUP_CYCLES > 0) ? CNT_W'(SETUP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_CYCLES - 1);

  state_t                 state;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] abort_sync;
  logic                   start_s;
  logic                   abort_s;
  logic                   start_prev;
  logic                   start_rise;
  logic                   start_rise_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       run_count;
  logic [CNT_W-1:0]       run_count_d;
  logic                   aborted;
  logic                   aborted_d;

  assign start_s    = start_sync[SYNC_STAGES-1];
  assign abort_s    = abort_sync[SYNC_STAGES-1];
  assign start_rise = start_s & ~start_prev;

  // The edge is registered once more so the FSM reacts SYNC_STAGES+1 clocks after the input edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync   <= '0;
      abort_sync   <= '0;
      start_prev   <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      start_sync   <= {start_sync[SYNC_STAGES-2:0], bus.ctrl_in[0]};
      abort_sync   <= {abort_sync[SYNC_STAGES-2:0], bus.ctrl_in[1]};
      start_prev   <= start_s;
      start_rise_q <= start_rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      run_count <= '0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      run_count <= run_count_d;
      aborted   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    run_count_d = run_count;
    aborted_d   = aborted;
    case (state)
      IDLE: begin
        // A start coinciding with a synchronized abort is dropped, not deferred.
        if (start_rise_q && !abort_s) begin
          run_count_d = '0;
          aborted_d   = 1'b0;
          if (SETUP_CYCLES == 0) begin
            state_d = RUN;
            cnt_d   = RUN_LOAD;
          end else begin
            state_d = ARM;
            cnt_d   = SETUP_LOAD;
          end
        end
      end
      ARM: begin
        if (abort_s) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (cnt == '0) begin
          state_d = RUN;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        // run_count freezes on the abort clock, so it reports completed RUN clocks only.
        if (abort_s) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          run_count_d = run_count + CNT_W'(1);
          if (cnt == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.run_out    = (state == RUN);
  assign bus.busy       = (state != IDLE);
  assign bus.done_pulse = (state == DONE);
  assign bus.aborted    = aborted;
  assign bus.run_count  = run_count;

`ifdef START_SEQUENCER_STATUS_EN
  logic [1:0] state_code;
  assign state_code = state;

  always_comb begin
    bus.status_readdata = '0;
    if (bus.status_chipselect) begin
      if (bus.status_address) begin
        bus.status_readdata = 32'(run_count);
      end else begin
        bus.status_readdata = {28'b0, aborted, (state != IDLE), state_code};
      end
    end
  end
`endif

endmodule

// File: tb/tb_start_sequencer.sv
// Randomized and directed bench for start_sequencer, checked against a timeline model
// that derives every output from the accept/abort clock numbers of the current sequence.
module tb_start_sequencer;

  localparam int SYNC = 2;
  localparam int S    = 4;
  localparam int R    = 10;
  localparam int W    = 16;
  localparam int HMAX = 20000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  start_sequencer_if #(.CNT_W(W)) bus();

  start_sequencer #(
    .SYNC_STAGES(SYNC),
    .SETUP_CYCLES(S),
    .RUN_CYCLES(R),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rbase = 0;
  logic [1:0] hist [HMAX];

  // Model: one record of the latest accepted sequence (accept clock, abort clock or -1).
  int have_seq = 0;
  int acc      = 0;
  int ab       = -1;

  function automatic logic [1:0] h(int idx);
    if (idx < rbase || idx < 0) return 2'b00;
    return hist[idx];
  endfunction

  function automatic int clampi(int v);
    if (v < 0) return 0;
    if (v > R) return R;
    return v;
  endfunction

  // 0 idle, 1 arm, 2 run, 3 done after clock x
  function automatic int phase(int x);
    int k;
    if (have_seq == 0) return 0;
    if (ab >= 0 && x >= ab) return 0;
    k = x - acc;
    if (k < 0) return 0;
    if (k < S) return 1;
    if (k < S + R) return 2;
    if (k == S + R) return 3;
    return 0;
  endfunction

  function automatic logic [W+3:0] expv(int x);
    int   ph;
    int   rc;
    logic abd;
    if (have_seq == 0) return '0;
    ph  = phase(x);
    abd = (ab >= 0 && x >= ab);
    rc  = abd ? clampi(ab - 1 - acc - S) : clampi(x - acc - S);
    return {ph == 2, ph != 0, ph == 3, abd, W'(rc)};
  endfunction

  function automatic logic [W+3:0] obs();
    return {bus.run_out, bus.busy, bus.done_pulse, bus.aborted, bus.run_count};
  endfunction

  // Input applied before clock e reaches the FSM as abort at e+SYNC and as a start edge at e+SYNC+1.
  task automatic model_edge(input int e);
    int         ph;
    logic [1:0] a0;
    logic [1:0] s1;
    logic [1:0] s2;
    ph = phase(e - 1);
    a0 = h(e - SYNC);
    s1 = h(e - SYNC - 1);
    s2 = h(e - SYNC - 2);
    if (ph == 0 && s1[0] && !s2[0] && !a0[1]) begin
      have_seq = 1;
      acc      = e;
      ab       = -1;
    end else if ((ph == 1 || ph == 2) && a0[1]) begin
      ab = e;
    end
  endtask

  task automatic step(input logic [1:0] v);
    bus.ctrl_in = v;
    hist[cyc+1] = v;
    @(posedge clk);
    cyc++;
    #1;
    if (!reset) model_edge(cyc);
  endtask

  task automatic test_reset();
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", obs());
    end
    step(2'b00);
    step(2'b00);
    reset    = 1'b0;
    rbase    = cyc + 1;
    have_seq = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b00);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
    end
  endtask

  task automatic test_basic();
    int n;
    int first_busy;
    int first_run;
    int runs;
    int dones;
    n          = cyc + 1;
    first_busy = -1;
    first_run  = -1;
    runs       = 0;
    dones      = 0;
    for (int i = 0; i < 25; i++) begin
      step(2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL basic_seq cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.busy && first_busy < 0) first_busy = cyc;
      if (bus.run_out && first_run < 0) first_run = cyc;
      if (bus.run_out) runs++;
      if (bus.done_pulse) dones++;
    end
    total++;
    if (first_busy != n + SYNC + 1) begin
      bad++;
      $display("FAIL arm_latency got=%0d exp=%0d", first_busy - n, SYNC + 1);
    end
    total++;
    if (first_run != n + SYNC + 1 + S) begin
      bad++;
      $display("FAIL run_latency got=%0d exp=%0d", first_run - n, SYNC + 1 + S);
    end
    total++;
    if (runs != R) begin
      bad++;
      $display("FAIL run_length got=%0d exp=%0d", runs, R);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL done_count got=%0d exp=1", dones);
    end
    total++;
    if (bus.run_count !== W'(R) || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL final_count got=%0d busy=%b exp=%0d busy=0", bus.run_count, bus.busy, R);
    end
  endtask

  task automatic test_hold();
    int dones;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step(2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL hold_no_retrigger cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.done_pulse) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL hold_done_count got=%0d exp=0", dones);
    end
    for (int i = 0; i < 28; i++) begin
      step(i < 3 ? 2'b00 : 2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL second_seq cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.done_pulse) dones++;
    end
    total++;
    if (dones != 1 || bus.run_count !== W'(R)) begin
      bad++;
      $display("FAIL second_seq_result dones=%0d count=%0d exp dones=1 count=%0d", dones, bus.run_count, R);
    end
  endtask

  task automatic test_abort();
    int         a0;
    int         dones;
    logic [1:0] v;
    a0    = acc;
    dones = 0;
    for (int i = 0; i < 3; i++) step(2'b00);
    for (int i = 0; i < 30; i++) begin
      v = 2'b01;
      if (have_seq != 0 && acc != a0 && cyc + 1 >= acc + S + 4) v = 2'b10;
      step(v);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL abort_seq cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.done_pulse) dones++;
    end
    total++;
    if (bus.aborted !== 1'b1 || bus.run_count !== W'(5) || bus.run_out !== 1'b0 || dones != 0) begin
      bad++;
      $display("FAIL abort_result aborted=%b count=%0d run=%b dones=%0d exp 1/5/0/0",
               bus.aborted, bus.run_count, bus.run_out, dones);
    end
    for (int i = 0; i < 28; i++) begin
      step(i < 3 ? 2'b00 : 2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL clean_after_abort cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
    end
    total++;
    if (bus.aborted !== 1'b0 || bus.run_count !== W'(R)) begin
      bad++;
      $display("FAIL abort_cleared aborted=%b count=%0d exp 0/%0d", bus.aborted, bus.run_count, R);
    end
  endtask

  task automatic test_simultaneous();
    int busy_cnt;
    int dones;
    busy_cnt = 0;
    dones    = 0;
    for (int i = 0; i < 3; i++) step(2'b00);
    for (int i = 0; i < 10; i++) begin
      step(2'b11);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL start_with_abort cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.busy) busy_cnt++;
    end
    total++;
    if (busy_cnt != 0) begin
      bad++;
      $display("FAIL start_with_abort_busy got=%0d exp=0", busy_cnt);
    end
    for (int i = 0; i < 3; i++) step(2'b00);
    for (int k = 0; k < 30; k++) begin
      step((k == 8 || k == 9) ? 2'b00 : 2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL rise_during_run cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.done_pulse) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL rise_during_run_dones got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    for (int i = 0; i < 3; i++) step(2'b00);
    for (int i = 0; i < 10; i++) step(2'b01);
    total++;
    if (bus.run_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_setup run=%b exp=1", bus.run_out);
    end
    #3;
    reset    = 1'b1;
    have_seq = 0;
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", obs());
    end
    step(2'b01);
    step(2'b01);
    reset = 1'b0;
    rbase = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      step(2'b01);
      total++;
      if (obs() !== expv(cyc)) begin
        bad++;
        $display("FAIL held_through_reset cyc=%0d got=%h exp=%h", cyc, obs(), expv(cyc));
      end
      if (bus.done_pulse) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL held_through_reset_dones got=%0d exp=1", dones);
    end
  endtask

`ifdef START_SEQUENCER_STATUS_EN
  task automatic test_status();
    int guard;
    for (int i = 0; i < 3; i++) step(2'b00);
    guard = 0;
    step(2'b01);
    while (!(phase(cyc) == 2 && cyc - acc - S == 3) && guard < 30) begin
      step(2'b01);
      guard++;
    end
    total++;
    if (guard >= 30) begin
      bad++;
      $display("FAIL status_reach_run timeout");
    end
    bus.status_chipselect = 1'b1;
    bus.status_address    = 1'b0;
    #1;
    total++;
    if (bus.status_readdata !== {28'b0, 1'b0, 1'b1, 2'b10}) begin
      bad++;
      $display("FAIL status_addr0_run got=%h exp=%h", bus.status_readdata, {28'b0, 4'b0110});
    end
    bus.status_address = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b01);
      total++;
      if (bus.status_readdata !== 32'(clampi(cyc - acc - S))) begin
        bad++;
        $display("FAIL status_addr1 cyc=%0d got=%0d exp=%0d", cyc, bus.status_readdata, clampi(cyc - acc - S));
      end
    end
    for (int i = 0; i < 6; i++) step(2'b10);
    bus.status_address = 1'b0;
    #1;
    total++;
    if (bus.status_readdata !== {28'b0, 1'b1, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL status_addr0_aborted got=%h exp=%h", bus.status_readdata, {28'b0, 4'b1000});
    end
    bus.status_chipselect = 1'b0;
    for (int i = 0; i < 3; i++) step(2'b00);
  endtask
`endif

  task automatic test_random();
    logic [1:0] v;
    int         len;
    for (int it = 0; it < 400 && cyc < HMAX - 100; it++) begin
      v   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) v[1] = 1'b0;
      len = $urandom_range(1, 25);
      for (int j = 0; j < len; j++) begin
        step(v);
        total++;
        if (obs() !== expv(cyc)) begin
          bad++;
          $display("FAIL random cyc=%0d ctrl=%b got=%h exp=%h", cyc, v, obs(), expv(cyc));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) hist[i] = 2'b00;
    reset       = 1'b1;
    bus.ctrl_in = 2'b00;
`ifdef START_SEQUENCER_STATUS_EN
    bus.status_address    = 1'b0;
    bus.status_chipselect = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_simultaneous();
    test_reset_mid();
`ifdef START_SEQUENCER_STATUS_EN
    test_status();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
